// File: rtl/hires_blit_master.sv
// rtl/hires_blit_master.sv - rectangle blit master driving the hires port decoder
//
// Purpose: streams a rectangle of pixel bytes to (write) or from (read) the hires
// graphics port. Each command programs the options port, then per row sets X and
// Y and moves w data bytes through port 0x82 using the port's x auto-increment.
//
// Ports:
//   clk, srst                      clock, synchronous active-high reset
//   cmd_valid/cmd_ready            command handshake
//   cmd_rd, cmd_gfx                direction (1 = read) and options bit0
//   cmd_x, cmd_y, cmd_w, cmd_h     rectangle origin and 1-based size
//   din/din_valid/din_ready        write pixel-byte stream in
//   dout/dout_valid/dout_ready     read pixel-byte stream out
//   TRS_A, TRS_D                   port address / data to the decoder
//   TRS_OUT, TRS_IN                active-low port-write / port-read qualifiers
//   io_access                      one-cycle strobe at the start of a bus cycle
//   hires_dout, hires_dout_rdy     read data returned by the port and its valid
//   busy, done, err                busy level, done pulse, sticky read timeout
`timescale 1ns/1ps
module hires_blit_master #(
  parameter int BUS_HOLD   = 4,
  parameter int RD_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       srst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_rd,
  input  logic       cmd_gfx,
  input  logic [6:0] cmd_x,
  input  logic [7:0] cmd_y,
  input  logic [6:0] cmd_w,
  input  logic [7:0] cmd_h,
  input  logic [7:0] din,
  input  logic       din_valid,
  output logic       din_ready,
  output logic [7:0] dout,
  output logic       dout_valid,
  input  logic       dout_ready,
  output logic [8:0] TRS_A,
  output logic [7:0] TRS_D,
  output logic       TRS_OUT,
  output logic       TRS_IN,
  output logic       io_access,
  input  logic [7:0] hires_dout,
  input  logic       hires_dout_rdy,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_OPT   = 4'd1;
  localparam logic [3:0] S_SETX  = 4'd2;
  localparam logic [3:0] S_SETY  = 4'd3;
  localparam logic [3:0] S_DWAIT = 4'd4;
  localparam logic [3:0] S_DBUS  = 4'd5;
  localparam logic [3:0] S_RWAIT = 4'd6;
  localparam logic [3:0] S_OWAIT = 4'd7;
  localparam logic [3:0] S_DONE  = 4'd8;

  localparam logic [3:0]  HOLD_LAST = 4'(BUS_HOLD - 1);
  // Timeout fires at the end of the cycle RD_TIMEOUT-1 cycles after io_access,
  // so err is visible exactly RD_TIMEOUT cycles after the strobe.
  localparam logic [15:0] TMO_LAST  = 16'(RD_TIMEOUT - 1);

  logic [3:0]  r_state;
  logic [3:0]  r_cnt;
  logic [15:0] r_tcnt;
  logic        r_rd;
  logic        r_gfx;
  logic [6:0]  r_x;
  logic [7:0]  r_y;
  logic [6:0]  r_w;
  logic [7:0]  r_h;
  logic [6:0]  r_col;
  logic [7:0]  r_row;
  logic [7:0]  r_data;
  logic        r_got;
  logic [7:0]  r_dout;
  logic        r_err;

  logic [3:0]  w_state_nxt;
  logic [3:0]  w_after_byte;
  logic        w_hold_end;
  logic        w_last_col;
  logic        w_last_row;
  logic        w_bus;

  assign w_hold_end = (r_cnt == HOLD_LAST);
  assign w_last_col = (r_col == r_w - 7'd1);
  assign w_last_row = (r_row == r_h - 8'd1);
  assign w_bus      = (r_state == S_OPT) || (r_state == S_SETX) ||
                      (r_state == S_SETY) || (r_state == S_DBUS);

  // Where to go once a data byte has fully moved: next column, next row or done.
  assign w_after_byte = !w_last_col ? (r_rd ? S_DBUS : S_DWAIT) :
                        (w_last_row ? S_DONE : S_SETX);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (cmd_valid) w_state_nxt = (cmd_w == 7'd0 || cmd_h == 8'd0) ? S_DONE : S_OPT;
      S_OPT:   if (w_hold_end) w_state_nxt = S_SETX;
      S_SETX:  if (w_hold_end) w_state_nxt = S_SETY;
      S_SETY:  if (w_hold_end) w_state_nxt = r_rd ? S_DBUS : S_DWAIT;
      S_DWAIT: if (din_valid) w_state_nxt = S_DBUS;
      S_DBUS: begin
        if (w_hold_end) begin
          if (r_rd) w_state_nxt = (r_got || hires_dout_rdy) ? S_OWAIT : S_RWAIT;
          else      w_state_nxt = w_after_byte;
        end
      end
      S_RWAIT: if (hires_dout_rdy || r_tcnt >= TMO_LAST) w_state_nxt = S_OWAIT;
      S_OWAIT: if (dout_ready) w_state_nxt = w_after_byte;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_tcnt  <= '0;
      r_rd    <= 1'b0;
      r_gfx   <= 1'b0;
      r_x     <= '0;
      r_y     <= '0;
      r_w     <= '0;
      r_h     <= '0;
      r_col   <= '0;
      r_row   <= '0;
      r_data  <= '0;
      r_got   <= 1'b0;
      r_dout  <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      // Hold counter restarts on every state change; all bus states have
      // distinct successors, so this marks the first cycle of each bus cycle.
      r_cnt   <= (w_state_nxt != r_state) ? 4'd0 : r_cnt + 4'd1;
      case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            r_rd  <= cmd_rd;
            r_gfx <= cmd_gfx;
            r_x   <= cmd_x;
            r_y   <= cmd_y;
            r_w   <= cmd_w;
            r_h   <= cmd_h;
            r_col <= '0;
            r_row <= '0;
            r_err <= 1'b0;
          end
        end
        S_DWAIT: if (din_valid) r_data <= din;
        S_DBUS: begin
          r_tcnt <= r_tcnt + 16'd1;
          if (r_rd && hires_dout_rdy) begin
            r_data <= hires_dout;
            r_got  <= 1'b1;
          end
          if (w_hold_end) begin
            if (r_rd) begin
              if (hires_dout_rdy)  r_dout <= hires_dout;
              else if (r_got)      r_dout <= r_data;
            end else begin
              if (w_last_col) begin
                r_col <= '0;
                if (!w_last_row) r_row <= r_row + 8'd1;
              end else begin
                r_col <= r_col + 7'd1;
              end
            end
          end
        end
        S_RWAIT: begin
          r_tcnt <= r_tcnt + 16'd1;
          if (hires_dout_rdy) begin
            r_dout <= hires_dout;
          end else if (r_tcnt >= TMO_LAST) begin
            r_err  <= 1'b1;
            r_dout <= 8'h00;
          end
        end
        S_OWAIT: begin
          if (dout_ready) begin
            if (w_last_col) begin
              r_col <= '0;
              if (!w_last_row) r_row <= r_row + 8'd1;
            end else begin
              r_col <= r_col + 7'd1;
            end
          end
        end
        default: ;
      endcase
      if (w_state_nxt == S_DBUS && r_state != S_DBUS) begin
        r_tcnt <= '0;
        r_got  <= 1'b0;
      end
    end
  end

  // Bus lines decode directly from state so an abort reaches the idle values
  // on the same edge that reset takes effect.
  always_comb begin
    TRS_A   = 9'h000;
    TRS_D   = 8'h00;
    TRS_OUT = 1'b1;
    TRS_IN  = 1'b1;
    case (r_state)
      S_OPT: begin
        TRS_A   = 9'h083;
        TRS_D   = r_rd ? {7'b1110000, r_gfx} : {7'b1011000, r_gfx};
        TRS_OUT = 1'b0;
      end
      S_SETX: begin
        TRS_A   = 9'h080;
        TRS_D   = {1'b0, r_x};
        TRS_OUT = 1'b0;
      end
      S_SETY: begin
        TRS_A   = 9'h081;
        TRS_D   = r_y + r_row;
        TRS_OUT = 1'b0;
      end
      S_DBUS: begin
        TRS_A = 9'h082;
        if (r_rd) begin
          TRS_IN = 1'b0;
        end else begin
          TRS_D   = r_data;
          TRS_OUT = 1'b0;
        end
      end
      default: ;
    endcase
  end

  assign io_access  = w_bus && (r_cnt == 4'd0);
  assign cmd_ready  = (r_state == S_IDLE);
  assign busy       = (r_state != S_IDLE);
  assign done       = (r_state == S_DONE);
  assign din_ready  = (r_state == S_DWAIT);
  assign dout_valid = (r_state == S_OWAIT);
  assign dout       = r_dout;
  assign err        = r_err;

endmodule
